cmd_encoder: RTL and testbench
==============================

// Module: cmd_encoder
// PURPOSE
//   Serialises one command into the byte stream read by the command decoder.
//   Takes a one-hot command flag vector plus operands and emits the opcode byte, then 0-2 operand bytes.
//   Input side uses a valid/ready handshake; output side is a byte stream with valid/ready.
//   Sits between the program sequencer/test driver and program memory or the fetch link.
// PARAMETERS
//   CNT_W   16   width of the emitted-command counter (only with CMD_ENC_STATS_EN)
// PORTS
//   CLK_          in   1      clock; all state updates on rising edge
//   RST_N_        in   1      asynchronous, active-low reset
//   CMD_FLGS_     in   6      one-hot command: [5]MOV [4]ADD [3]CMP [2]JMP [1]JEQ [0]JGG
//   CMD_ARG0_     in   8      operand 0: MOV dst / jump target
//   CMD_ARG1_     in   8      operand 1: MOV src value
//   CMD_VALID_    in   1      command present
//   CMD_READY_    out  1      encoder can accept a command
//   BYTE_OUT_     out  8      stream byte
//   BYTE_VALID_   out  1      BYTE_OUT_ valid
//   BYTE_READY_   in   1      consumer takes the byte this cycle
//   ERR_          out  1      1-cycle pulse: invalid flag vector was dropped
//   CMD_CNT_      out  CNT_W  commands fully emitted (only with CMD_ENC_STATS_EN)
// BEHAVIOUR
//   - Opcodes: MOV=77 (0x4D), ADD=65 (0x41), CMP=67 (0x43), JMP=74 (0x4A), JEQ=69 (0x45), JGG=71 (0x47).
//   - Sizes: MOV 3 bytes (op, ARG0, ARG1); ADD/CMP 1 byte (op); JMP/JEQ/JGG 2 bytes (op, ARG0).
//   - FSM states: IDLE, OP, A0, A1. CMD_READY_ = (state==IDLE); registered decode of state only.
//     CMD_READY_ has no combinational path from any input.
//   - Accept: in IDLE, when CMD_VALID_ is 1, flags/args are latched.
//     The next state is OP when the flags are valid; it stays IDLE when they are invalid.
//   - OP/A0/A1: BYTE_VALID_=1 and BYTE_OUT_ = opcode/ARG0/ARG1.
//     The byte and BYTE_VALID_ are held stable until BYTE_VALID_&BYTE_READY_.
//   - Transfer advances the FSM: OP -> A0 (MOV, jumps) or IDLE (ADD, CMP).
//     A0 -> A1 (MOV) or IDLE (jumps). A1 -> IDLE.
//   - Latency: first byte is valid 1 cycle after accept.
//     An N-byte command with BYTE_READY_ held at 1 occupies N+1 cycles, accept included.
//   - Inputs are ignored outside IDLE; the latched copy is used, so the source may change
//     CMD_* after accept.
//   - Invalid flags (all zero, or more than one bit set): the command is consumed and no byte is emitted.
//     ERR_=1 for exactly the cycle after accept. The FSM stays IDLE, so the next command can be
//     accepted in that same cycle.
//   - BYTE_READY_ asserted while BYTE_VALID_=0 has no effect.
//   - Reset (async, any state): state=IDLE, BYTE_VALID_=0, BYTE_OUT_=8'h00, ERR_=0, latched flags/args=0.
//     CMD_READY_=1 (IDLE). A partially emitted command is abandoned; no residual bytes appear after release.
// CONFIGURATION
//   CMD_ENC_STATS_EN defined:
//     - CMD_CNT_ increments by 1 on the transfer of a command's last byte.
//     - Dropped invalid commands do not count.
//     - Wraps from 2^CNT_W-1 to 0. Reset value is 0.
//   CMD_ENC_STATS_EN undefined:
//     - No counter logic.
//     - CMD_CNT_ port is absent.
// TESTING
//   1. ADD (6'b010000), BYTE_READY_=1 -> single byte 0x41 one cycle after accept.
//      CMD_READY_=1 the following cycle.
//   2. MOV, ARG0=0x05, ARG1=0xA3, BYTE_READY_=1 -> 0x4D, 0x05, 0xA3 on 3 consecutive cycles.
//      Then IDLE.
//   3. JEQ, ARG0=0x10, BYTE_READY_=0 for 3 cycles -> 0x45 held 4 cycles with BYTE_VALID_=1.
//      Then 0x10, then IDLE.
//   4. Flags 6'b000011, then 6'b000000 -> no BYTE_VALID_.
//      ERR_ pulses once per command; CMD_READY_ stays 1.
//   5. RST_N_ low for 1 cycle after the MOV opcode transfers -> BYTE_VALID_=0 immediately.
//      No 0x05/0xA3 is emitted after release; the next ADD gives 0x41.
//   6. With CMD_ENC_STATS_EN, CNT_W=2: 5 valid commands plus 1 invalid -> CMD_CNT_=1 (wrapped).
//      Without the macro, the bench compiles without the port.

Source files
------------

// File: rtl/cmd_encoder_if.sv
// Command-in / byte-out handshake bundle for cmd_encoder.
// CMD_ENC_STATS_EN adds the emitted-command counter signal.
interface cmd_encoder_if #(
    parameter int CNT_W = 16
);
    logic [5:0] cmd_flgs_;
    logic [7:0] cmd_arg0_;
    logic [7:0] cmd_arg1_;
    logic       cmd_valid_;
    logic       cmd_ready_;
    logic [7:0] byte_out_;
    logic       byte_valid_;
    logic       byte_ready_;
    logic       err_;
`ifdef CMD_ENC_STATS_EN
    logic [CNT_W-1:0] cmd_cnt_;

    modport master (
        output cmd_flgs_, cmd_arg0_, cmd_arg1_, cmd_valid_, byte_ready_,
        input  cmd_ready_, byte_out_, byte_valid_, err_, cmd_cnt_
    );

    modport slave (
        input  cmd_flgs_, cmd_arg0_, cmd_arg1_, cmd_valid_, byte_ready_,
        output cmd_ready_, byte_out_, byte_valid_, err_, cmd_cnt_
    );
`else
    modport master (
        output cmd_flgs_, cmd_arg0_, cmd_arg1_, cmd_valid_, byte_ready_,
        input  cmd_ready_, byte_out_, byte_valid_, err_
    );

    modport slave (
        input  cmd_flgs_, cmd_arg0_, cmd_arg1_, cmd_valid_, byte_ready_,
        output cmd_ready_, byte_out_, byte_valid_, err_
    );
`endif
endinterface

// File: rtl/cmd_encoder.sv
// Serialises a one-hot command plus operands into opcode/operand bytes.
// Optional CMD_ENC_STATS_EN adds a wrapping count of fully emitted commands.
module cmd_encoder #(
    parameter int CNT_W = 16
) (
    input logic        clk_,
    input logic        rst_n_,
    cmd_encoder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        OP,
        A0,
        A1
    } state_t;

    state_t     state;
    logic [5:0] flg_q;
    logic [7:0] arg0_q;
    logic [7:0] arg1_q;
    logic [7:0] byte_q;
    logic       bvalid_q;
    logic       err_q;

    logic       is_mov;
    logic       one_byte;
    logic       xfer;

    function automatic logic [7:0] opcode(input logic [5:0] f);
        logic [7:0] op;
        op = 8'h00;
        unique case (1'b1)
            f[5]: op = 8'h4D;
            f[4]: op = 8'h41;
            f[3]: op = 8'h43;
            f[2]: op = 8'h4A;
            f[1]: op = 8'h45;
            f[0]: op = 8'h47;
            default: op = 8'h00;
        endcase
        return op;
    endfunction

    // Size decode of the latched command and byte-transfer strobe
    assign is_mov   = flg_q[5];
    assign one_byte = flg_q[4] | flg_q[3];
    assign xfer     = bvalid_q & bus.byte_ready_;

    assign bus.cmd_ready_  = (state == IDLE);
    assign bus.byte_out_   = byte_q;
    assign bus.byte_valid_ = bvalid_q;
    assign bus.err_        = err_q;

    // Command FSM: accept, then walk opcode/operand bytes on each transfer
    always_ff @(posedge clk_ or negedge rst_n_) begin
        if (!rst_n_) begin
            state    <= IDLE;
            flg_q    <= '0;
            arg0_q   <= '0;
            arg1_q   <= '0;
            byte_q   <= 8'h00;
            bvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid_) begin
                        flg_q  <= bus.cmd_flgs_;
                        arg0_q <= bus.cmd_arg0_;
                        arg1_q <= bus.cmd_arg1_;
                        if ($onehot(bus.cmd_flgs_)) begin
                            state    <= OP;
                            byte_q   <= opcode(bus.cmd_flgs_);
                            bvalid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                OP: begin
                    if (xfer) begin
                        if (one_byte) begin
                            state    <= IDLE;
                            byte_q   <= 8'h00;
                            bvalid_q <= 1'b0;
                        end else begin
                            state  <= A0;
                            byte_q <= arg0_q;
                        end
                    end
                end
                A0: begin
                    if (xfer) begin
                        if (is_mov) begin
                            state  <= A1;
                            byte_q <= arg1_q;
                        end else begin
                            state    <= IDLE;
                            byte_q   <= 8'h00;
                            bvalid_q <= 1'b0;
                        end
                    end
                end
                A1: begin
                    if (xfer) begin
                        state    <= IDLE;
                        byte_q   <= 8'h00;
                        bvalid_q <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bvalid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef CMD_ENC_STATS_EN
    logic             last_xfer;
    logic [CNT_W-1:0] cnt_q;

    assign last_xfer = xfer &
                       (((state == OP) & one_byte) |
                        ((state == A0) & ~is_mov) |
                        (state == A1));

    assign bus.cmd_cnt_ = cnt_q;

    // Count commands whose final byte has been taken; wraps naturally
    always_ff @(posedge clk_ or negedge rst_n_) begin
        if (!rst_n_) begin
            cnt_q <= '0;
        end else if (last_xfer) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_cmd_encoder.sv
// Directed bench for cmd_encoder; CMD_ENC_STATS_EN also checks the counter
// with a 2-bit width so the wrap is exercised.
module tb_cmd_encoder;
`ifdef CMD_ENC_STATS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic clk_ = 1'b0;
    logic rst_n_ = 1'b0;
    int   checks = 0;
    int   errors = 0;

    cmd_encoder_if #(.CNT_W(CNT_W)) bus ();

    cmd_encoder #(.CNT_W(CNT_W)) dut (
        .clk_  (clk_),
        .rst_n_(rst_n_),
        .bus   (bus)
    );

    always #5 clk_ = ~clk_;

    task automatic tick();
        @(posedge clk_);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [5:0] f, input logic [7:0] a0,
                       input logic [7:0] a1);
        bus.cmd_flgs_  = f;
        bus.cmd_arg0_  = a0;
        bus.cmd_arg1_  = a1;
        bus.cmd_valid_ = 1'b1;
    endtask

    // Send one command with byte_ready held high and check its bytes
    task automatic emit(input string tag, input logic [5:0] f,
                        input logic [7:0] a0, input logic [7:0] a1,
                        input int n, input logic [7:0] b0,
                        input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] exp_b[3];
        exp_b[0] = b0;
        exp_b[1] = b1;
        exp_b[2] = b2;
        bus.byte_ready_ = 1'b1;
        put(f, a0, a1);
        tick();
        bus.cmd_valid_ = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, 32'(bus.byte_valid_), 32'd1);
            chk({tag, "_byte"}, 32'(bus.byte_out_), 32'(exp_b[i]));
            tick();
        end
        chk({tag, "_done"}, 32'(bus.byte_valid_), 32'd0);
        chk({tag, "_ready"}, 32'(bus.cmd_ready_), 32'd1);
    endtask

    initial begin
        bus.cmd_flgs_   = '0;
        bus.cmd_arg0_   = '0;
        bus.cmd_arg1_   = '0;
        bus.cmd_valid_  = 1'b0;
        bus.byte_ready_ = 1'b0;

        // Reset state
        #12;
        chk("rst_valid", 32'(bus.byte_valid_), 32'd0);
        chk("rst_byte", 32'(bus.byte_out_), 32'h00);
        chk("rst_err", 32'(bus.err_), 32'd0);
        chk("rst_ready", 32'(bus.cmd_ready_), 32'd1);
`ifdef CMD_ENC_STATS_EN
        chk("rst_cnt", 32'(bus.cmd_cnt_), 32'd0);
`endif
        rst_n_ = 1'b1;
        tick();

        // 1: ADD, one byte
        bus.byte_ready_ = 1'b1;
        put(6'b010000, 8'h11, 8'h22);
        tick();
        bus.cmd_valid_ = 1'b0;
        chk("add_valid", 32'(bus.byte_valid_), 32'd1);
        chk("add_byte", 32'(bus.byte_out_), 32'h41);
        chk("add_busy", 32'(bus.cmd_ready_), 32'd0);
        tick();
        chk("add_done", 32'(bus.byte_valid_), 32'd0);
        chk("add_ready", 32'(bus.cmd_ready_), 32'd1);

        // 2: MOV, inputs scrambled after accept must be ignored
        put(6'b100000, 8'h05, 8'hA3);
        tick();
        put(6'b010000, 8'hFF, 8'hFF);
        chk("mov_op", 32'(bus.byte_out_), 32'h4D);
        chk("mov_opv", 32'(bus.byte_valid_), 32'd1);
        tick();
        chk("mov_a0", 32'(bus.byte_out_), 32'h05);
        tick();
        bus.cmd_valid_ = 1'b0;
        chk("mov_a1", 32'(bus.byte_out_), 32'hA3);
        chk("mov_a1v", 32'(bus.byte_valid_), 32'd1);
        tick();
        chk("mov_done", 32'(bus.byte_valid_), 32'd0);
        chk("mov_ready", 32'(bus.cmd_ready_), 32'd1);

        // 3: JEQ with back-pressure
        bus.byte_ready_ = 1'b0;
        put(6'b000010, 8'h10, 8'h99);
        tick();
        bus.cmd_valid_ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("jeq_hold_v", 32'(bus.byte_valid_), 32'd1);
            chk("jeq_hold_b", 32'(bus.byte_out_), 32'h45);
            tick();
        end
        bus.byte_ready_ = 1'b1;
        chk("jeq_last_v", 32'(bus.byte_valid_), 32'd1);
        chk("jeq_last_b", 32'(bus.byte_out_), 32'h45);
        tick();
        chk("jeq_a0", 32'(bus.byte_out_), 32'h10);
        chk("jeq_a0v", 32'(bus.byte_valid_), 32'd1);
        tick();
        chk("jeq_done", 32'(bus.byte_valid_), 32'd0);
        chk("jeq_ready", 32'(bus.cmd_ready_), 32'd1);

        // 4: invalid flags, back to back
        put(6'b000011, 8'h01, 8'h02);
        tick();
        chk("inv1_err", 32'(bus.err_), 32'd1);
        chk("inv1_valid", 32'(bus.byte_valid_), 32'd0);
        chk("inv1_ready", 32'(bus.cmd_ready_), 32'd1);
        put(6'b000000, 8'h01, 8'h02);
        tick();
        bus.cmd_valid_ = 1'b0;
        chk("inv2_err", 32'(bus.err_), 32'd1);
        chk("inv2_valid", 32'(bus.byte_valid_), 32'd0);
        chk("inv2_ready", 32'(bus.cmd_ready_), 32'd1);
        tick();
        chk("inv_err_clr", 32'(bus.err_), 32'd0);
        chk("inv_valid2", 32'(bus.byte_valid_), 32'd0);

        // 5: reset mid-MOV abandons the command
        put(6'b100000, 8'h05, 8'hA3);
        tick();
        bus.cmd_valid_ = 1'b0;
        chk("rmov_op", 32'(bus.byte_out_), 32'h4D);
        tick();
        chk("rmov_a0", 32'(bus.byte_out_), 32'h05);
        rst_n_ = 1'b0;
        #1;
        chk("rmid_valid", 32'(bus.byte_valid_), 32'd0);
        chk("rmid_byte", 32'(bus.byte_out_), 32'h00);
        chk("rmid_ready", 32'(bus.cmd_ready_), 32'd1);
`ifdef CMD_ENC_STATS_EN
        chk("rmid_cnt", 32'(bus.cmd_cnt_), 32'd0);
`endif
        tick();
        rst_n_ = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rpost_valid", 32'(bus.byte_valid_), 32'd0);
            tick();
        end
        emit("radd", 6'b010000, 8'h00, 8'h00, 1, 8'h41, 8'h00, 8'h00);
`ifdef CMD_ENC_STATS_EN
        chk("cnt_1", 32'(bus.cmd_cnt_), 32'd1);
`endif

        // 6: remaining opcodes; counter wraps at 4 with CNT_W=2
        emit("cmp", 6'b001000, 8'h33, 8'h44, 1, 8'h43, 8'h00, 8'h00);
        emit("jmp", 6'b000100, 8'h22, 8'h55, 2, 8'h4A, 8'h22, 8'h00);
        emit("jgg", 6'b000001, 8'h7E, 8'h66, 2, 8'h47, 8'h7E, 8'h00);
`ifdef CMD_ENC_STATS_EN
        chk("cnt_wrap0", 32'(bus.cmd_cnt_), 32'd0);
`endif
        put(6'b100001, 8'h01, 8'h02);
        tick();
        bus.cmd_valid_ = 1'b0;
        chk("inv3_err", 32'(bus.err_), 32'd1);
        chk("inv3_valid", 32'(bus.byte_valid_), 32'd0);
        tick();
        emit("mov2", 6'b100000, 8'h01, 8'h02, 3, 8'h4D, 8'h01, 8'h02);
`ifdef CMD_ENC_STATS_EN
        chk("cnt_final", 32'(bus.cmd_cnt_), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
